// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one Avalon data-bus transaction per request, with
// store lane steering and load alignment/extension/LWL-LWR merging.
module mips_cpu_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [2:0]        loadcontrol,
  input  logic [1:0]        storesize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rt_old,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        lc_q, lc_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       rt_q, rt_d;

  logic [1:0]  k;
  logic        ld_mis;
  logic        st_mis;
  logic        req_err;
  logic [3:0]  st_be;
  logic [31:0] st_wd;

  assign k = addr[1:0];

  always_comb begin
    ld_mis = 1'b0;
    unique case (loadcontrol)
      3'b010, 3'b011: ld_mis = k[0];
      3'b101:         ld_mis = |k;
      default:        ld_mis = 1'b0;
    endcase
  end

  always_comb begin
    st_mis = 1'b0;
    st_be  = 4'hF;
    st_wd  = wdata;
    unique case (storesize)
      2'b00: begin
        st_be = 4'b0001 << k;
        st_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_mis = k[0];
        st_be  = k[1] ? 4'b1100 : 4'b0011;
        st_wd  = {2{wdata[15:0]}};
      end
      2'b10: st_mis = |k;
      default: st_mis = 1'b0;
    endcase
  end

  assign req_err = (data_read & data_write)
                 | (data_read & ((loadcontrol == 3'b100) | ld_mis))
                 | (data_write & ((storesize == 2'b11) | st_mis));

  // Load alignment uses the lane and rt captured at acceptance
  logic [31:0] w;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_res;

  assign w  = mem_readdata;
  assign lb = w[{k_q, 3'b000} +: 8];
  assign lh = k_q[1] ? w[31:16] : w[15:0];

  always_comb begin
    ld_res = w;
    unique case (lc_q)
      3'b000: ld_res = {{24{lb[7]}}, lb};
      3'b001: ld_res = {24'h0, lb};
      3'b010: ld_res = {{16{lh[15]}}, lh};
      3'b011: ld_res = {16'h0, lh};
      3'b110: begin
        unique case (k_q)
          2'd0: ld_res = {w[7:0], rt_q[23:0]};
          2'd1: ld_res = {w[15:0], rt_q[15:0]};
          2'd2: ld_res = {w[23:0], rt_q[7:0]};
          default: ld_res = w;
        endcase
      end
      3'b111: begin
        unique case (k_q)
          2'd0: ld_res = w;
          2'd1: ld_res = {rt_q[31:24], w[31:8]};
          2'd2: ld_res = {rt_q[31:16], w[31:16]};
          default: ld_res = {rt_q[31:8], w[31:24]};
        endcase
      end
      default: ld_res = w;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    be_d    = be_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    lc_d    = lc_q;
    k_d     = k_q;
    rt_d    = rt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && (data_read || data_write)) begin
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            lc_d    = loadcontrol;
            k_d     = k;
            rt_d    = rt_old;
            if (data_read) begin
              rd_d = 1'b1;
              be_d = 4'hF;
            end else begin
              wr_d = 1'b1;
              be_d = st_be;
              wd_d = st_wd;
            end
          end
        end
      end
      ACCESS: begin
        if (!mem_waitrequest) begin
          state_d = RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rdata_d = ld_res;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      lc_q    <= '0;
      k_q     <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      lc_q    <= lc_d;
      k_q     <= k_d;
      rt_q    <= rt_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == RESP);
  assign addr_error     = err_q;
  assign rdata          = rdata_q;
  assign mem_address    = addr_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wd_q;

endmodule
